i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/anc_pkg.sv | 14 +
 rtl/i2s_clk_gen.sv | 47 ++++
 rtl/i2s_tx.sv | 117 +++++++++++
 tb/tb_i2s_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
// Shared definitions for the ANC audio path (I2S rx/tx and friends).
package anc_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int FRAME_BITS = 32;

   // Serial-port sequencing state, common to the tx and future rx blocks.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } i2s_state_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator: divides clk_i down to bclk as a registered data
// output and flags the bclk falling edge as a one-cycle strobe.
module i2s_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic bclk_o,
   output logic fall_o
);

   logic [7:0] div_q, div_d;
   logic       bclk_q, bclk_d;
   logic       tc;

   assign tc     = run_i && (div_q == 8'(CLK_DIV - 1));
   assign fall_o = tc && bclk_q;
   assign bclk_o = bclk_q;

   // Divider next state; held at zero (bclk low) whenever the port is stopped.
   always_comb begin
      div_d  = div_q;
      bclk_d = bclk_q;
      if (!run_i) begin
         div_d  = '0;
         bclk_d = 1'b0;
      end else if (tc) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
      end else begin
         div_d  = div_q + 8'd1;
      end
   end

   // Divider and bclk registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q  <= '0;
         bclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         bclk_q <= bclk_d;
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: mono sample is held, loaded once per frame as {W,W}
// and shifted out MSB first with the I2S one-bit delay after lrclk.
module i2s_tx
   import anc_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int SAMPLE_W = anc_pkg::SAMPLE_W
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       enable_in,
   input  logic                       ready_in,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   output logic                       bclk_out,
   output logic                       lrclk_out,
   output logic                       sdata_out,
   output logic                       overrun_out,
   output logic                       busy_out
);

   localparam int BC_W = $clog2(FRAME_BITS);

   i2s_state_e            state_q, state_d;
   logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [SAMPLE_W-1:0]   hold_q, hold_d;
   logic                  hold_vld_q, hold_vld_d;
   logic [SAMPLE_W-1:0]   last_q, last_d;
   logic                  ovr_q, ovr_d;

   logic                  fall;
   logic                  frame_edge;
   logic                  load;
   logic [SAMPLE_W-1:0]   word;

   i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk_i  (clk_in),
      .rst_i  (rst_in),
      .run_i  (state_q != ST_IDLE),
      .bclk_o (bclk_out),
      .fall_o (fall)
   );

   // Frame boundary is the fall that moves bit_cnt from 0 to 1. A drain
   // that is cancelled right on the boundary still loads so the next
   // frame carries audio rather than shifted-out zeros.
   assign frame_edge = fall && (bit_cnt_q == '0);
   assign load       = frame_edge && ((state_q == ST_RUN) || enable_in);
   assign word       = hold_vld_q ? hold_q : last_q;

   // FSM next state: stop requests take effect at the next frame boundary.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable_in) state_d = ST_RUN;
         ST_RUN:   if (!enable_in) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable_in)       state_d = ST_RUN;
            else if (frame_edge) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Hold register, overrun detect, frame counter and shifter next state.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      last_d     = last_q;
      ovr_d      = ready_in && hold_vld_q && !load;
      if (load) begin
         hold_vld_d = 1'b0;
         last_d     = word;
      end
      // A sample arriving on the load cycle survives into the next frame.
      if (ready_in) begin
         hold_d     = sample_in;
         hold_vld_d = 1'b1;
      end
      if (state_d == ST_IDLE) begin
         bit_cnt_d = '0;
         shift_d   = '0;
      end else if (fall) begin
         bit_cnt_d = bit_cnt_q + BC_W'(1);
         shift_d   = load ? {word, word} : {shift_q[FRAME_BITS-2:0], 1'b0};
      end
   end

   // State registers; reset drops every output immediately.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         last_q     <= '0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         last_q     <= last_d;
         ovr_q      <= ovr_d;
      end
   end

   assign lrclk_out   = bit_cnt_q[BC_W-1];
   assign sdata_out   = shift_q[FRAME_BITS-1];
   assign overrun_out = ovr_q;
   assign busy_out    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: an I2S receiver decodes the pins; expected words and
// overrun counts come from frame arithmetic over a log of offered samples.
module tb_i2s_tx;

   localparam int D  = 4;
   localparam int FR = 64 * D;

   logic               clk = 1'b0, rst = 1'b1, en = 1'b0, rdy = 1'b0;
   logic signed [15:0] smp = '0;
   logic               bclk, lrclk, sdata, ovr, busy;

   i2s_tx #(.CLK_DIV(D)) dut (
      .clk_in(clk), .rst_in(rst), .enable_in(en), .ready_in(rdy),
      .sample_in(smp), .bclk_out(bclk), .lrclk_out(lrclk),
      .sdata_out(sdata), .overrun_out(ovr), .busy_out(busy)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge number n, cyc == n.
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Log of accepted samples (edge at which ready was sampled).
   int unsigned rdy_e[$];
   logic [15:0] rdy_v[$];
   always @(posedge clk) begin
      if (rst) begin
         rdy_e.delete();
         rdy_v.delete();
      end else if (rdy) begin
         rdy_e.push_back(cyc + 1);
         rdy_v.push_back(smp);
      end
   end

   // I2S receiver: sample at bclk rise; the bit after an lrclk change closes
   // the previous channel's word.
   logic [15:0] rx_w[$];
   bit          rx_c[$];
   int unsigned ovr_e[$];
   logic        bclk_p = 1'b0, lr_p = 1'b0;
   logic [15:0] acc = '0;
   always @(negedge clk) begin
      if (ovr) ovr_e.push_back(cyc);
      bclk_p <= bclk;
      if (rst || !busy) begin
         lr_p <= 1'b0;
         acc  <= '0;
      end else if (bclk && !bclk_p) begin
         if (lrclk != lr_p) begin
            rx_w.push_back({acc[14:0], sdata});
            rx_c.push_back(lr_p);
            acc  <= '0;
            lr_p <= lrclk;
         end else begin
            acc <= {acc[14:0], sdata};
         end
      end
   end

   int          checks = 0, errors = 0;
   int unsigned t0 = 0;
   int          base = 0;

   // Edge at which frame k of the current run is loaded.
   function automatic int unsigned L(int k);
      return t0 + 2 * D + FR * k;
   endfunction

   // Frame k carries the most recent sample offered strictly before its load.
   function automatic logic [15:0] exp_word(int k);
      logic [15:0] w = '0;
      foreach (rdy_e[i]) if (rdy_e[i] < L(k)) w = rdy_v[i];
      return w;
   endfunction

   // Every sample after the first within one load window is an overrun.
   function automatic int exp_ovr(int ka, int kb);
      int s = 0;
      for (int k = ka; k < kb; k++) begin
         int c = 0;
         foreach (rdy_e[i]) if (rdy_e[i] >= L(k) && rdy_e[i] < L(k + 1)) c++;
         if (c > 1) s += c - 1;
      end
      return s;
   endfunction

   function automatic int pulses(int unsigned lo, int unsigned hi);
      int n = 0;
      foreach (ovr_e[i]) if (ovr_e[i] >= lo && ovr_e[i] <= hi) n++;
      return n;
   endfunction

   function automatic int next_k();
      int k = 0;
      while (L(k) <= cyc + 1) k++;
      return k;
   endfunction

   // Return at a negedge such that inputs set now are sampled at edge e.
   task automatic go_to(int unsigned e);
      while (cyc + 1 < e) @(negedge clk);
   endtask

   task automatic send(int unsigned e, logic [15:0] v);
      go_to(e);
      rdy = 1'b1;
      smp = v;
      @(negedge clk);
      rdy = 1'b0;
   endtask

   task automatic wait_rx(int n, int lim, output bit ok);
      int t = 0;
      while (rx_w.size() < n && t < lim) begin
         @(negedge clk);
         t++;
      end
      ok = (rx_w.size() >= n);
   endtask

   // Start a run at the current negedge and check the first bclk rise.
   task automatic start_run(string nm);
      t0   = cyc + 1;
      base = rx_w.size();
      en   = 1'b1;
      while (cyc < t0 + D - 1) @(negedge clk);
      checks++;
      if (bclk !== 1'b0) begin errors++; $display("FAIL %s_bclk_pre got=%b exp=0", nm, bclk); end
      @(negedge clk);
      checks++;
      if (bclk !== 1'b1 || lrclk !== 1'b0) begin
         errors++; $display("FAIL %s_bclk_rise got=%b%b exp=10", nm, bclk, lrclk);
      end
   endtask

   // Compare both slots of frames ka..kb of the current run with the model.
   task automatic cmp_frames(string nm, int ka, int kb);
      bit ok;
      wait_rx(base + 2 * kb + 2, (kb - ka + 3) * FR, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL %s_timeout got=%0d words exp=%0d", nm, rx_w.size(), base + 2 * kb + 2);
      end else begin
         for (int k = ka; k <= kb; k++)
            for (int c = 0; c < 2; c++) begin
               checks++;
               if (rx_w[base + 2 * k + c] !== exp_word(k) || rx_c[base + 2 * k + c] !== 1'(c)) begin
                  errors++;
                  $display("FAIL %s_f%0d_ch%0d got=%h/%0d exp=%h/%0d", nm, k, c,
                           rx_w[base + 2 * k + c], rx_c[base + 2 * k + c], exp_word(k), c);
               end
            end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bclk, lrclk, sdata, ovr, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_outputs got=%b exp=00000", {bclk, lrclk, sdata, ovr, busy});
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if ({bclk, busy} !== 2'b0) begin
         errors++; $display("FAIL idle_no_enable got=%b exp=00", {bclk, busy});
      end
   endtask

   task automatic test_first_word();
      rdy = 1'b1;
      smp = 16'h8001;
      start_run("first");
      rdy = 1'b0;
      cmp_frames("first", 0, 0);
      checks++;
      if (rx_w.size() > base && rx_w[base] !== 16'h8001) begin
         errors++; $display("FAIL first_left got=%h exp=8001", rx_w[base]);
      end
   endtask

   task automatic test_repeat();
      bit ok;
      int k = next_k();
      send(L(k) + 20, 16'h1234);
      wait_rx(base + 2 * k + 8, 6 * FR, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL repeat_timeout got=%0d exp=%0d", rx_w.size(), base + 2 * k + 8); end
      else
         for (int i = 2 * k + 2; i < 2 * k + 8; i++) begin
            checks++;
            if (rx_w[base + i] !== 16'h1234) begin
               errors++; $display("FAIL repeat_slot%0d got=%h exp=1234", i, rx_w[base + i]);
            end
         end
      checks++;
      if (pulses(L(k) + 1, L(k + 4)) !== 0) begin
         errors++; $display("FAIL repeat_overrun got=%0d exp=0", pulses(L(k) + 1, L(k + 4)));
      end
   endtask

   task automatic test_overrun();
      int k = next_k();
      send(L(k) + 10, 16'hAAAA);
      send(L(k) + 60, 16'h5555);
      cmp_frames("overrun", k + 1, k + 1);
      checks++;
      if (rx_w[base + 2 * k + 2] !== 16'h5555) begin
         errors++; $display("FAIL overrun_word got=%h exp=5555", rx_w[base + 2 * k + 2]);
      end
      checks++;
      if (pulses(L(k) + 1, L(k + 1)) !== 1) begin
         errors++; $display("FAIL overrun_count got=%0d exp=1", pulses(L(k) + 1, L(k + 1)));
      end
   endtask

   task automatic test_load_collision();
      int k = next_k() + 1;
      send(L(k) - 50, 16'h0F0F);
      send(L(k), 16'hF0F0);
      cmp_frames("collide", k, k + 1);
      checks++;
      if (rx_w[base + 2 * k] !== 16'h0F0F || rx_w[base + 2 * k + 2] !== 16'hF0F0) begin
         errors++; $display("FAIL collide_words got=%h,%h exp=0f0f,f0f0", rx_w[base + 2 * k], rx_w[base + 2 * k + 2]);
      end
      checks++;
      if (pulses(L(k) - 49, L(k + 1) + 1) !== 0) begin
         errors++; $display("FAIL collide_overrun got=%0d exp=0", pulses(L(k) - 49, L(k + 1) + 1));
      end
   endtask

   task automatic test_random();
      int k0 = next_k() + 1;
      for (int j = 0; j < 6; j++) begin
         int n  = (j == 0) ? 2 : int'($urandom_range(0, 2));
         int o1 = (j == 0) ? 0 : int'($urandom_range(0, 120));
         int o2 = int'($urandom_range(o1 + 1, FR - 1));
         if (n >= 1) send(L(k0 + j) + o1, 16'($urandom()));
         if (n == 2) send(L(k0 + j) + o2, 16'($urandom()));
      end
      cmp_frames("random", k0, k0 + 6);
      checks++;
      if (pulses(L(k0) + 1, L(k0 + 6)) !== exp_ovr(k0, k0 + 6)) begin
         errors++; $display("FAIL random_overrun got=%0d exp=%0d", pulses(L(k0) + 1, L(k0 + 6)), exp_ovr(k0, k0 + 6));
      end
   endtask

   task automatic test_stop_restart();
      int k = next_k();
      go_to(L(k) + 40);
      en = 1'b0;
      while (cyc < L(k + 1) - 1) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got=%b exp=1", busy); end
      @(negedge clk);
      checks++;
      if ({bclk, lrclk, sdata, busy} !== 4'b0) begin
         errors++; $display("FAIL stop_idle got=%b exp=0000", {bclk, lrclk, sdata, busy});
      end
      checks++;
      if (rx_w.size() !== base + 2 * k + 2) begin
         errors++; $display("FAIL stop_words got=%0d exp=%0d", rx_w.size(), base + 2 * k + 2);
      end
      cmp_frames("drain", k, k);
      send(cyc + 20, 16'($urandom()));
      repeat (300) @(negedge clk);
      checks++;
      if (rx_w.size() !== base + 2 * k + 2 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_quiet got=%0d/%b exp=%0d/0", rx_w.size(), busy, base + 2 * k + 2);
      end
      start_run("restart");
      cmp_frames("restart", 0, 1);
   endtask

   task automatic test_reset_mid();
      int k = next_k();
      send(L(k) + 5, 16'h7777);
      go_to(L(k) + FR / 2 + 40);
      checks++;
      if (lrclk !== 1'b1) begin errors++; $display("FAIL mid_right_slot got=%b exp=1", lrclk); end
      #2 rst = 1'b1;
      en = 1'b0;
      #1;
      checks++;
      if ({bclk, lrclk, sdata, busy} !== 4'b0) begin
         errors++; $display("FAIL async_reset got=%b exp=0000", {bclk, lrclk, sdata, busy});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ovr, busy} !== 2'b0) begin
         errors++; $display("FAIL post_reset got=%b exp=00", {ovr, busy});
      end
      start_run("after_reset");
      cmp_frames("after_reset", 0, 0);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_first_word();
      test_repeat();
      test_overrun();
      test_load_collision();
      test_random();
      test_stop_restart();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
